// File: rtl/disp_pkg.sv
// Shared types and constants for the Julia-set job dispatcher.
// Contents: FSM state encoding, worker count/index width, index-to-one-hot helper.
package disp_pkg;

  localparam int unsigned NUM_WORKERS = 16;
  localparam int unsigned WIDX_W      = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DRAIN    = 2'd2
  } disp_state_t;

  // Expand a worker index into a one-hot worker vector.
  function automatic logic [NUM_WORKERS-1:0] widx_onehot(input logic [WIDX_W-1:0] idx);
    logic [NUM_WORKERS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/disp_prio_enc.sv
// Fixed-priority encoder: returns the lowest set index of req (bit 0 highest priority).
// Ports:
//   req      in  NUM_WORKERS  request vector
//   idx_c    out WIDX_W       lowest-index set bit (0 when no request)
//   valid_c  out 1            at least one request bit is set
module disp_prio_enc
  import disp_pkg::*;
(
  input  logic [NUM_WORKERS-1:0] req,
  output logic [WIDX_W-1:0]      idx_c,
  output logic                   valid_c
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx_c   = '0;
    valid_c = |req;
    for (int i = int'(NUM_WORKERS) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx_c = WIDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/dispatch_controller.sv
// Job dispatcher for the 16-worker Julia-set engine. After a start pulse it hands
// one job per clock to the lowest-index idle, non-pending worker until NUM_JOBS
// jobs are issued, then waits for all outstanding workers to finish.
// Ports:
//   wr_clk                       in   clock, rising edge
//   wr_n_rst                     in   asynchronous active-low reset
//   wr_start_calc                in   one-cycle pulse starting a run (honoured only when idle)
//   wr_done0..wr_done15          in   per-worker idle/done flag (1 = idle)
//   worker_to_assign             out  index of the last assigned worker (holds between assignments)
//   jw_begin                     out  one-cycle strobe: a job went to worker_to_assign
//   wr_start0..wr_start15        out  one-cycle per-worker start strobe
module dispatch_controller
  import disp_pkg::*;
#(
  parameter int unsigned NUM_JOBS = 307200
) (
  input  logic              wr_clk,
  input  logic              wr_n_rst,
  input  logic              wr_start_calc,
  input  logic              wr_done0,
  input  logic              wr_done1,
  input  logic              wr_done2,
  input  logic              wr_done3,
  input  logic              wr_done4,
  input  logic              wr_done5,
  input  logic              wr_done6,
  input  logic              wr_done7,
  input  logic              wr_done8,
  input  logic              wr_done9,
  input  logic              wr_done10,
  input  logic              wr_done11,
  input  logic              wr_done12,
  input  logic              wr_done13,
  input  logic              wr_done14,
  input  logic              wr_done15,
  output logic [WIDX_W-1:0] worker_to_assign,
  output logic              jw_begin,
  output logic              wr_start0,
  output logic              wr_start1,
  output logic              wr_start2,
  output logic              wr_start3,
  output logic              wr_start4,
  output logic              wr_start5,
  output logic              wr_start6,
  output logic              wr_start7,
  output logic              wr_start8,
  output logic              wr_start9,
  output logic              wr_start10,
  output logic              wr_start11,
  output logic              wr_start12,
  output logic              wr_start13,
  output logic              wr_start14,
  output logic              wr_start15
);

  localparam int unsigned CNT_W = $clog2(NUM_JOBS + 1);

  disp_state_t            state_q, state_d;
  logic [NUM_WORKERS-1:0] done_c;
  logic [NUM_WORKERS-1:0] done_q;
  logic [NUM_WORKERS-1:0] rise_c;
  logic [NUM_WORKERS-1:0] elig_c;
  logic [NUM_WORKERS-1:0] sel_oh_c;
  logic [NUM_WORKERS-1:0] pending_q, pending_d;
  logic [NUM_WORKERS-1:0] start_q, start_d;
  logic [WIDX_W-1:0]      sel_idx_c;
  logic                   sel_valid_c;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDX_W-1:0]      wta_q, wta_d;
  logic                   begin_q;
  logic                   assign_c;
  logic                   clear_cnt_c;

  assign done_c = {wr_done15, wr_done14, wr_done13, wr_done12,
                   wr_done11, wr_done10, wr_done9,  wr_done8,
                   wr_done7,  wr_done6,  wr_done5,  wr_done4,
                   wr_done3,  wr_done2,  wr_done1,  wr_done0};

  // A rising done flag marks completion of the worker's outstanding job.
  assign rise_c   = done_c & ~done_q;
  assign elig_c   = done_c & ~pending_q;
  assign sel_oh_c = widx_onehot(sel_idx_c);

  disp_prio_enc u_prio_enc (
    .req     (elig_c),
    .idx_c   (sel_idx_c),
    .valid_c (sel_valid_c)
  );

  // FSM state register.
  always_ff @(posedge wr_clk or negedge wr_n_rst) begin
    if (!wr_n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and assignment decision.
  always_comb begin
    state_d     = state_q;
    assign_c    = 1'b0;
    clear_cnt_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_start_calc) begin
          state_d     = DISPATCH;
          clear_cnt_c = 1'b1;
        end
      end
      DISPATCH: begin
        // Counter never exceeds NUM_JOBS, so equality is the exit test.
        if (cnt_q == CNT_W'(NUM_JOBS)) begin
          state_d = DRAIN;
        end else if (sel_valid_c) begin
          assign_c = 1'b1;
        end
      end
      DRAIN: begin
        if (pending_q == '0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next values for pending mask, counter and registered outputs.
  always_comb begin
    // Assignment overrides a coincident completion on the same worker.
    pending_d = (pending_q & ~rise_c) | (assign_c ? sel_oh_c : '0);
    start_d   = assign_c ? sel_oh_c : '0;
    wta_d     = assign_c ? sel_idx_c : wta_q;
    cnt_d     = cnt_q;
    if (clear_cnt_c) begin
      cnt_d = '0;
    end else if (assign_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge wr_clk or negedge wr_n_rst) begin
    if (!wr_n_rst) begin
      done_q    <= '0;
      pending_q <= '0;
      start_q   <= '0;
      begin_q   <= 1'b0;
      wta_q     <= '0;
      cnt_q     <= '0;
    end else begin
      done_q    <= done_c;
      pending_q <= pending_d;
      start_q   <= start_d;
      begin_q   <= assign_c;
      wta_q     <= wta_d;
      cnt_q     <= cnt_d;
    end
  end

  assign worker_to_assign = wta_q;
  assign jw_begin         = begin_q;
  assign wr_start0        = start_q[0];
  assign wr_start1        = start_q[1];
  assign wr_start2        = start_q[2];
  assign wr_start3        = start_q[3];
  assign wr_start4        = start_q[4];
  assign wr_start5        = start_q[5];
  assign wr_start6        = start_q[6];
  assign wr_start7        = start_q[7];
  assign wr_start8        = start_q[8];
  assign wr_start9        = start_q[9];
  assign wr_start10       = start_q[10];
  assign wr_start11       = start_q[11];
  assign wr_start12       = start_q[12];
  assign wr_start13       = start_q[13];
  assign wr_start14       = start_q[14];
  assign wr_start15       = start_q[15];

endmodule

// File: tb/tb_dispatch_controller.sv
// Self-checking bench for dispatch_controller with a queue-based scoreboard fed by
// a behavioural model of the dispatch rules.
module tb_dispatch_controller;

  localparam int NJ = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] done_v = 16'hFFFF;
  logic [15:0] start_v;
  logic [3:0]  wta;
  logic        jwb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dispatch_controller #(.NUM_JOBS(NJ)) dut (
    .wr_clk           (clk),
    .wr_n_rst         (rst_n),
    .wr_start_calc    (start),
    .wr_done0         (done_v[0]),
    .wr_done1         (done_v[1]),
    .wr_done2         (done_v[2]),
    .wr_done3         (done_v[3]),
    .wr_done4         (done_v[4]),
    .wr_done5         (done_v[5]),
    .wr_done6         (done_v[6]),
    .wr_done7         (done_v[7]),
    .wr_done8         (done_v[8]),
    .wr_done9         (done_v[9]),
    .wr_done10        (done_v[10]),
    .wr_done11        (done_v[11]),
    .wr_done12        (done_v[12]),
    .wr_done13        (done_v[13]),
    .wr_done14        (done_v[14]),
    .wr_done15        (done_v[15]),
    .worker_to_assign (wta),
    .jw_begin         (jwb),
    .wr_start0        (start_v[0]),
    .wr_start1        (start_v[1]),
    .wr_start2        (start_v[2]),
    .wr_start3        (start_v[3]),
    .wr_start4        (start_v[4]),
    .wr_start5        (start_v[5]),
    .wr_start6        (start_v[6]),
    .wr_start7        (start_v[7]),
    .wr_start8        (start_v[8]),
    .wr_start9        (start_v[9]),
    .wr_start10       (start_v[10]),
    .wr_start11       (start_v[11]),
    .wr_start12       (start_v[12]),
    .wr_start13       (start_v[13]),
    .wr_start14       (start_v[14]),
    .wr_start15       (start_v[15])
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outcome of one clock edge: assigned worker (-1 = none) and worker_to_assign.
  typedef struct {
    int pick;
    int wta;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: run phase (0 idle, 1 issuing, 2 waiting), jobs issued, outstanding set.
  int          m_phase;
  int          m_issued;
  int          m_last;
  int          m_pick;
  int          m_issued_old;
  bit          m_any_pend;
  bit          m_pend[16];
  logic [15:0] m_prev;
  exp_t        m_e;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase  = 0;
        m_issued = 0;
        m_last   = 0;
        m_prev   = '0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        exp_q.delete();
      end else begin
        m_pick       = -1;
        m_issued_old = m_issued;
        m_any_pend   = 1'b0;
        foreach (m_pend[i]) m_any_pend |= m_pend[i];
        if (m_phase == 1 && m_issued < NJ) begin
          for (int i = 0; i < 16; i++) begin
            if (m_pick < 0 && done_v[i] && !m_pend[i]) m_pick = i;
          end
        end
        for (int i = 0; i < 16; i++) begin
          if (done_v[i] && !m_prev[i]) m_pend[i] = 1'b0;
        end
        if (m_pick >= 0) begin
          m_pend[m_pick] = 1'b1;
          m_issued++;
          m_last = m_pick;
        end
        case (m_phase)
          0: if (start) begin m_phase = 1; m_issued = 0; end
          1: if (m_issued_old == NJ) m_phase = 2;
          default: if (!m_any_pend) m_phase = 0;
        endcase
        m_prev   = done_v;
        m_e.pick = m_pick;
        m_e.wta  = m_last;
        exp_q.push_back(m_e);
      end
    end
  end

  // Monitor: pops one expectation per cycle and compares on the falling edge.
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_jw_begin", 32'(jwb), 32'd0);
        check("rst_wr_start", 32'(start_v), 32'd0);
        check("rst_worker_to_assign", 32'(wta), 32'd0);
      end else if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("jw_begin", 32'(jwb), (mon_e.pick >= 0) ? 32'd1 : 32'd0);
        check("wr_start", 32'(start_v), (mon_e.pick >= 0) ? (32'd1 << mon_e.pick) : 32'd0);
        check("worker_to_assign", 32'(wta), 32'(mon_e.wta));
      end else begin
        check("idle_jw_begin", 32'(jwb), 32'd0);
        check("idle_wr_start", 32'(start_v), 32'd0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Drop the given workers' done flags for one cycle, then raise them again.
  task automatic blip(input logic [15:0] m);
    done_v = done_v & ~m;
    tick(1);
    done_v = done_v | m;
    tick(1);
  endtask

  initial begin
    // Reset with every worker idle, then three quiet cycles.
    rst_n  = 1'b0;
    done_v = 16'hFFFF;
    tick(3);
    rst_n = 1'b1;
    tick(3);

    // Full sweep: 16 assignments 0..15, then stall.
    pulse_start();
    tick(20);

    // Reissue to workers 0 and 3 (jobs 17, 18).
    blip(16'h0009);
    tick(4);

    // Workers 5 and 7 complete: jobs 19, 20, then drain.
    blip(16'h00A0);
    tick(4);
    pulse_start();
    tick(3);
    blip(16'hFFFF);
    tick(4);

    // Workers 14 and 15 busy: fresh run assigns only 0..13.
    done_v[15:14] = 2'b00;
    tick(1);
    pulse_start();
    tick(20);

    // Random completions until the run finishes.
    for (int c = 0; c < 80; c++) begin
      done_v = done_v ^ 16'($urandom & $urandom);
      tick(1);
    end
    for (int c = 0; c < 20; c++) blip(16'hFFFF);
    tick(4);

    // Reset in the middle of a dispatch burst.
    rst_n  = 1'b0;
    done_v = 16'hFFFF;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    pulse_start();
    tick(4);
    check("burst_active", 32'(jwb), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_jw_begin", 32'(jwb), 32'd0);
    check("async_rst_wr_start", 32'(start_v), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(6);

    // After reset nothing is pending: a new run restarts from worker 0.
    pulse_start();
    tick(22);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
